// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FPU select encodings and constants for the FP issue controller.
package fpu_issue_ctrl_pkg;

  localparam logic [2:0] FPU_ASEL = 3'd0;
  localparam logic [2:0] FPU_BSEL = 3'd1;
  localparam logic [2:0] FPU_SGNJ = 3'd2;
  localparam logic [2:0] FPU_ADD  = 3'd3;
  localparam logic [2:0] FPU_MADD = 3'd4;
  localparam logic [2:0] FPU_CVT  = 3'd5;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  function automatic logic is_core_op(input logic [2:0] sel);
    return (sel == FPU_ADD) || (sel == FPU_MADD) || (sel == FPU_CVT);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_sgnj.sv
// fpu_sgnj_unit: single-cycle sign-inject and A/B pass-through result mux.
module fpu_sgnj_unit
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        sel,
  input  logic [2:0]        fnc3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result
);

  logic sgn;

  always_comb begin
    sgn = op_a[DATA_W-1];
    case (fnc3)
      3'd0:    sgn = op_b[DATA_W-1];
      3'd1:    sgn = ~op_b[DATA_W-1];
      3'd2:    sgn = op_a[DATA_W-1] ^ op_b[DATA_W-1];
      default: sgn = op_a[DATA_W-1];
    endcase
  end

  // Unknown select codes fall back to pass-A.
  always_comb begin
    case (sel)
      FPU_SGNJ: result = {sgn, op_a[DATA_W-2:0]};
      FPU_BSEL: result = op_b;
      default:  result = op_a;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: local trivial ops, req/ack/done handshake to the FP core.
// Optional watchdog on WAIT/DRAIN enabled by defining FPU_TIMEOUT_EN.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fpu_valid,
  input  logic [2:0]        fpusel,
  input  logic [2:0]        fnc3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] op_c,
  input  logic              kill,
  output logic              stall,
  output logic              fpu_done,
  output logic [DATA_W-1:0] fpu_result,
  output logic              core_req,
  output logic [2:0]        core_op,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  output logic [DATA_W-1:0] core_c,
  input  logic              core_ack,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              fpu_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e            state;
  logic              pending;
  logic [2:0]        fnc3_q;

  logic              acc_idle;
  logic              acc_drain;
  logic              accept;
  logic              to_fire;
  logic [2:0]        nxt_sel;
  logic [2:0]        lu_fnc3;
  logic [DATA_W-1:0] lu_a;
  logic [DATA_W-1:0] lu_b;
  logic [DATA_W-1:0] lu_res;

  assign acc_idle  = fpu_valid && !kill && (state == S_IDLE || state == S_DONE);
  assign acc_drain = fpu_valid && !kill && (state == S_DRAIN) && !pending;
  assign accept    = acc_idle || acc_drain;

  assign stall = accept || (state == S_REQ) || (state == S_WAIT) ||
                 (state == S_DRAIN && pending);

  // Local results come from live inputs in the accept cycle, otherwise from
  // the op parked in the operand registers while a drain finishes.
  assign nxt_sel = accept ? fpusel : core_op;
  assign lu_fnc3 = accept ? fnc3   : fnc3_q;
  assign lu_a    = accept ? op_a   : core_a;
  assign lu_b    = accept ? op_b   : core_b;

  fpu_sgnj_unit #(
    .DATA_W (DATA_W)
  ) u_sgnj (
    .sel    (nxt_sel),
    .fnc3   (lu_fnc3),
    .op_a   (lu_a),
    .op_b   (lu_b),
    .result (lu_res)
  );

`ifdef FPU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] to_cnt;

  // REQ always precedes WAIT and kill in WAIT re-enters DRAIN, so clearing
  // there gives a fresh count on every WAIT/DRAIN entry.
  always_ff @(posedge clk) begin
    if (rst || !(state == S_WAIT || state == S_DRAIN) || (state == S_WAIT && kill))
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign to_fire = !core_done && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                   ((state == S_WAIT && !kill) || state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (rst)
      fpu_timeout <= 1'b0;
    else if (to_fire)
      fpu_timeout <= 1'b1;
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign to_fire            = 1'b0;
  assign fpu_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      fpu_done   <= 1'b0;
      fpu_result <= '0;
      core_req   <= 1'b0;
      core_op    <= '0;
      core_a     <= '0;
      core_b     <= '0;
      core_c     <= '0;
      fnc3_q     <= '0;
    end else begin
      fpu_done <= 1'b0;
      if (accept) begin
        core_op <= fpusel;
        fnc3_q  <= fnc3;
        core_a  <= op_a;
        core_b  <= op_b;
        core_c  <= op_c;
      end
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (acc_idle) begin
            if (is_core_op(fpusel)) begin
              state    <= S_REQ;
              core_req <= 1'b1;
            end else begin
              state      <= S_DONE;
              fpu_done   <= 1'b1;
              fpu_result <= lu_res;
            end
          end
        end
        S_REQ: begin
          if (kill) begin
            core_req <= 1'b0;
            state    <= core_ack ? S_DRAIN : S_IDLE;
          end else if (core_ack) begin
            core_req <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (kill) begin
            state <= S_DRAIN;
          end else if (core_done) begin
            state      <= S_DONE;
            fpu_done   <= 1'b1;
            fpu_result <= core_result;
          end else if (to_fire) begin
            state      <= S_DONE;
            fpu_done   <= 1'b1;
            fpu_result <= DATA_W'(CANON_NAN);
          end
        end
        S_DRAIN: begin
          if (acc_drain) pending <= 1'b1;
          if (kill)      pending <= 1'b0;
          // The drained result is discarded; only a parked op continues.
          if (core_done || to_fire) begin
            pending <= 1'b0;
            if (!kill && (pending || acc_drain)) begin
              if (is_core_op(nxt_sel)) begin
                state    <= S_REQ;
                core_req <= 1'b1;
              end else begin
                state      <= S_DONE;
                fpu_done   <= 1'b1;
                fpu_result <= lu_res;
              end
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_no_valid_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(fpu_valid && (state == S_REQ || state == S_WAIT)));

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sits directly downstream of the EX-stage control decoder.
- Consumes the one-cycle `fpu_valid` pulse, the `fpusel` op code and the forwarded FP operands.
- Executes trivial FP ops (sign-inject, pass-A, pass-B) locally in one cycle.
- Issues ADD, MADD and CVT to the external multi-cycle FP core over a req/ack + done handshake.
- Holds the pipeline with `stall` until the result is ready.

Parameters:
- DATA_W, 32: operand/result width.
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT; used only with FPU_TIMEOUT_EN.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- fpu_valid  in  1  one-cycle new-FP-op pulse from EX control
- fpusel  in  3  op select, FPU_* encodings from control_sel.vh
- fnc3  in  3  inst[14:12]; sign-inject variant
- op_a, op_b, op_c  in  DATA_W  forwarded operands
- kill  in  1  pipeline kill (trap/redirect); abandons the current op
- stall  out  1  hold upstream stages
- fpu_done  out  1  one-cycle pulse; fpu_result valid
- fpu_result  out  DATA_W  result, held until the next op completes
- core_req  out  1  request to FP core
- core_op  out  3  registered fpusel
- core_a, core_b, core_c  out  DATA_W  registered operands
- core_ack  in  1  core accepted request
- core_done  in  1  one-cycle core completion pulse
- core_result  in  DATA_W  core result, valid with core_done
- fpu_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - All outputs 0, including registered operands and result.
  - rst mid-operation aborts immediately; any later core_done is ignored.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Op acceptance:
  - Accepted when fpu_valid=1 && kill=0 && state in {IDLE, DONE}.
  - On accept, the op and operands are registered.
- Local ops (SGNJ, ASEL, BSEL): go to DONE next cycle with the result registered. Latency is 1.
  - ASEL → op_a.
  - BSEL → op_b.
  - SGNJ → {s, op_a[30:0]}, where s = op_b[31] (fnc3=0), ~op_b[31] (fnc3=1), op_a[31]^op_b[31] (fnc3=2). Other fnc3 values give op_a unchanged.
- Core ops (ADD, MADD, CVT): go to REQ.
- Other fpusel values: treated as ASEL.
- REQ:
  - core_req=1; core_op/a/b/c are stable while core_req is high.
  - core_ack=1 → WAIT. core_ack in the same cycle core_req rises is legal.
- WAIT: core_done=1 → capture core_result → DONE.
- DONE:
  - fpu_done=1 for exactly one cycle, then IDLE.
  - An accept in DONE is handled as from IDLE, so back-to-back ops incur no bubble.
- Stall:
  - stall = (accept-eligible fpu_valid) || state in {REQ, WAIT} || (state==DRAIN && pending).
  - stall is 0 in DONE.
  - stall is combinational in the accept cycle.
- Kill:
  - Kill has priority over fpu_valid in the same cycle; the op is dropped.
  - IDLE/DONE → IDLE, with no fpu_done.
  - REQ with core_ack=0 → IDLE; core_req drops next cycle.
  - REQ with core_ack=1, or WAIT → DRAIN.
- DRAIN:
  - Waits for core_done and discards the result; fpu_result is unchanged.
  - fpu_valid accepted in DRAIN sets `pending` and registers the op/operands. stall is held until the drain ends.
  - On core_done: pending → REQ (or → DONE next cycle for a local op); otherwise → IDLE.
  - A further kill in DRAIN clears pending.
- Protocol errors:
  - core_done outside WAIT/DRAIN is ignored.
  - fpu_valid in REQ/WAIT is ignored; it is a simulation-assertion error.

Optional Feature:
- FPU_TIMEOUT_EN defined:
  - A counter counts cycles in WAIT or DRAIN and resets on state entry.
  - When it reaches TIMEOUT_CYCLES without core_done:
    - From WAIT: → DONE with fpu_result=32'h7FC00000.
    - From DRAIN: proceed as if core_done had arrived.
  - In both cases fpu_timeout is set and stays set until rst.
- FPU_TIMEOUT_EN undefined: no counter; fpu_timeout is tied 0; WAIT/DRAIN are unbounded.

Decomposition:
- Shared package (control_sel.vh): FPU_* op encodings and the canonical NaN constant.
- Module-local: state encoding.
- One sub-module: fpu_sgnj_unit, the combinational sign-inject plus ASEL/BSEL result mux.

Test Plan:
- ASEL: fpu_valid, op_a=32'h3F800000 → stall=1 in cycle T; fpu_done=1 and fpu_result=32'h3F800000 at T+1; stall=0.
- SGNJ: fnc3=2, op_a=32'hBF800000, op_b=32'h80000000 → fpu_result=32'h3F800000 at T+1.
- ADD:
  - fpu_valid → core_req at T+1; ack at T+3; core_done at T+6 with 32'h40400000.
  - Expect fpu_done at T+7; stall high T..T+6, low at T+7.
- Kill in WAIT, then new ASEL accepted during DRAIN: old core_result discarded; ASEL result done one cycle after core_done; no spurious fpu_done.
- Back-to-back: ADD completes, ASEL fpu_valid in its DONE cycle → ASEL fpu_done next cycle.
- FPU_TIMEOUT_EN, TIMEOUT_CYCLES=4, core never asserts done → fpu_result=32'h7FC00000, fpu_timeout=1; rst clears fpu_timeout.
